// File: rtl/aibcr3_dcc_cal_pkg.sv
// aibcr3_dcc_cal_pkg: shared types and helpers for the DCC calibration controller.
// Contents: FSM state enum, binary-to-gray helper, counter width helpers.
package aibcr3_dcc_cal_pkg;
  typedef enum logic [2:0] {
    IDLE, SETTLE, MEASURE, DECIDE, DONE, TRACK_SETTLE, TRACK_MEASURE, TRACK_DECIDE
  } cal_state_e;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic int scnt_w(input int settle_cyc);
    return $clog2(settle_cyc + 1);
  endfunction
  function automatic int acnt_w(input int avg_cnt);
    return $clog2(avg_cnt) + 1;
  endfunction
endpackage

// File: rtl/aibcr3_dcc_cal_vote.sv
// aibcr3_dcc_cal_vote: synchronizes the duty detector outputs and tallies up/down votes.
// Ports: clk_dcd/nrst clock and async reset; t_up_i/t_down_i raw detector inputs;
// clr_i clears the tallies; en_i counts one sample per cycle; up_cnt_o/dn_cnt_o tallies;
// win_done_o high on the cycle that takes the last sample of the window.
module aibcr3_dcc_cal_vote
  import aibcr3_dcc_cal_pkg::*;
#(
  parameter int AVG_CNT = 8,
  parameter int ACNT_W  = acnt_w(AVG_CNT)
) (
  input  logic              clk_dcd,
  input  logic              nrst,
  input  logic              t_up_i,
  input  logic              t_down_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ACNT_W-1:0] up_cnt_o,
  output logic [ACNT_W-1:0] dn_cnt_o,
  output logic              win_done_o
);
  logic [1:0] up_sync_q, dn_sync_q;
  logic [ACNT_W-1:0] up_q, dn_q, smp_q;
  logic up, dn;
  always_ff @(posedge clk_dcd or negedge nrst) begin
    if (!nrst) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      up_sync_q <= {up_sync_q[0], t_up_i};
      dn_sync_q <= {dn_sync_q[0], t_down_i};
    end
  end
  // Conflicting or absent decisions carry no vote either way.
  assign up = up_sync_q[1] & ~dn_sync_q[1];
  assign dn = dn_sync_q[1] & ~up_sync_q[1];
  always_ff @(posedge clk_dcd or negedge nrst) begin
    if (!nrst) begin
      up_q  <= '0;
      dn_q  <= '0;
      smp_q <= '0;
    end else if (clr_i) begin
      up_q  <= '0;
      dn_q  <= '0;
      smp_q <= '0;
    end else if (en_i) begin
      up_q  <= up_q + ACNT_W'(up);
      dn_q  <= dn_q + ACNT_W'(dn);
      smp_q <= smp_q + ACNT_W'(1);
    end
  end
  assign up_cnt_o   = up_q;
  assign dn_cnt_o   = dn_q;
  assign win_done_o = en_i && (smp_q == ACNT_W'(AVG_CNT - 1));
endmodule

// File: rtl/aibcr3_dcc_cal_ctrl.sv
// aibcr3_dcc_cal_ctrl: SAR search plus optional tracking of the DCC delay-line trim code.
// Ports: clk_dcd/nrst clock and async active-low reset; t_up/t_down detector decisions;
// rb_dcc_byp forces mid-scale and done; rb_cont_cal enables tracking after lock;
// reinit restarts calibration; dcc_code/dcc_code_gry binary and gray trim code;
// dcc_done code valid; cal_busy search or tracking in progress.
module aibcr3_dcc_cal_ctrl
  import aibcr3_dcc_cal_pkg::*;
#(
  parameter int CODE_W     = 8,
  parameter int SETTLE_CYC = 16,
  parameter int AVG_CNT    = 8
) (
  input  logic              clk_dcd,
  input  logic              nrst,
  input  logic              t_up,
  input  logic              t_down,
  input  logic              rb_dcc_byp,
  input  logic              rb_cont_cal,
  input  logic              reinit,
  output logic [CODE_W-1:0] dcc_code,
  output logic [CODE_W-1:0] dcc_code_gry,
  output logic              dcc_done,
  output logic              cal_busy
);
  localparam int SCNT_W = scnt_w(SETTLE_CYC);
  localparam int ACNT_W = acnt_w(AVG_CNT);
  localparam int IDX_W  = $clog2(CODE_W);
  localparam logic [CODE_W-1:0] MID     = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] MAX     = '1;
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(CODE_W - 1);
  localparam logic [ACNT_W:0]   HALF    = (ACNT_W+1)'(AVG_CNT / 2);
  cal_state_e state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CODE_W-1:0] code_q, code_d, gry_q;
  logic done_q, done_d;
  logic [ACNT_W-1:0] up_cnt, dn_cnt;
  logic win_done, settle_st, meas_st, settle_end, trk_up, trk_dn;
  assign settle_st  = state_q == SETTLE || state_q == TRACK_SETTLE;
  assign meas_st    = state_q == MEASURE || state_q == TRACK_MEASURE;
  assign settle_end = scnt_q == SCNT_W'(SETTLE_CYC - 1);
  aibcr3_dcc_cal_vote #(.AVG_CNT(AVG_CNT), .ACNT_W(ACNT_W)) u_vote (
    .clk_dcd    (clk_dcd),
    .nrst       (nrst),
    .t_up_i     (t_up),
    .t_down_i   (t_down),
    .clr_i      (settle_st),
    .en_i       (meas_st),
    .up_cnt_o   (up_cnt),
    .dn_cnt_o   (dn_cnt),
    .win_done_o (win_done)
  );
  always_ff @(posedge clk_dcd or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (rb_dcc_byp || reinit) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:          state_d = SETTLE;
        SETTLE:        state_d = settle_end ? MEASURE : SETTLE;
        MEASURE:       state_d = win_done ? DECIDE : MEASURE;
        DECIDE:        state_d = (idx_q == '0) ? DONE : SETTLE;
        DONE:          state_d = rb_cont_cal ? TRACK_SETTLE : DONE;
        TRACK_SETTLE:  state_d = settle_end ? TRACK_MEASURE : TRACK_SETTLE;
        TRACK_MEASURE: state_d = win_done ? TRACK_DECIDE : TRACK_MEASURE;
        TRACK_DECIDE:  state_d = rb_cont_cal ? TRACK_SETTLE : DONE;
        default:       state_d = IDLE;
      endcase
    end
  end
  always_comb cal_busy = !(state_q == IDLE || state_q == DONE);
  // Tracking steps only on a clear majority of at least half a window.
  assign trk_up = {1'b0, up_cnt} >= {1'b0, dn_cnt} + HALF;
  assign trk_dn = {1'b0, dn_cnt} >= {1'b0, up_cnt} + HALF;
  always_comb begin
    code_d = code_q;
    idx_d  = idx_q;
    if (state_d == IDLE) begin
      code_d = MID;
      idx_d  = IDX_TOP;
    end else if (state_q == DECIDE) begin
      code_d[idx_q] = up_cnt > dn_cnt;
      if (idx_q != '0) begin
        code_d[idx_q - IDX_W'(1)] = 1'b1;
        idx_d = idx_q - IDX_W'(1);
      end
    end else if (state_q == TRACK_DECIDE) begin
      code_d = (trk_up && code_q != MAX) ? code_q + CODE_W'(1) :
               (trk_dn && code_q != '0)  ? code_q - CODE_W'(1) : code_q;
    end
  end
  assign done_d = rb_dcc_byp || state_d == DONE || state_d == TRACK_SETTLE ||
                  state_d == TRACK_MEASURE || state_d == TRACK_DECIDE;
  assign scnt_d = (settle_st && state_d == state_q) ? scnt_q + SCNT_W'(1) : '0;
  always_ff @(posedge clk_dcd or negedge nrst) begin
    if (!nrst) begin
      scnt_q <= '0;
      idx_q  <= IDX_TOP;
      code_q <= MID;
      gry_q  <= CODE_W'(bin2gray(32'(MID)));
      done_q <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      idx_q  <= idx_d;
      code_q <= code_d;
      gry_q  <= CODE_W'(bin2gray(32'(code_d)));
      done_q <= done_d;
    end
  end
  assign dcc_code     = code_q;
  assign dcc_code_gry = gry_q;
  assign dcc_done     = done_q;
endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// tb_aibcr3_dcc_cal_ctrl: directed self-checking bench for the DCC calibration controller.
module tb_aibcr3_dcc_cal_ctrl;
  logic clk = 1'b0;
  logic nrst, rb_dcc_byp, rb_cont_cal, reinit;
  logic t_up, t_down, up_v, dn_v;
  logic [1:0] mode;
  logic [2:0] pcnt = '0;
  logic [7:0] dcc_code, dcc_code_gry;
  logic dcc_done, cal_busy;
  int n_assert = 0;
  int n_fail = 0;
  int cyc;
  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 3'd1;
  // mode 0: ideal detector with threshold 0x5B; 1: direct levels; 2: 5-up/3-down periodic pattern
  assign t_up   = (mode == 2'd0) ? (dcc_code < 8'h5B) : (mode == 2'd1) ? up_v : (pcnt < 3'd5);
  assign t_down = (mode == 2'd0) ? !(dcc_code < 8'h5B) : (mode == 2'd1) ? dn_v : !(pcnt < 3'd5);
  aibcr3_dcc_cal_ctrl #(.CODE_W(8), .SETTLE_CYC(16), .AVG_CNT(8)) dut (
    .clk_dcd      (clk),
    .nrst         (nrst),
    .t_up         (t_up),
    .t_down       (t_down),
    .rb_dcc_byp   (rb_dcc_byp),
    .rb_cont_cal  (rb_cont_cal),
    .reinit       (reinit),
    .dcc_code     (dcc_code),
    .dcc_code_gry (dcc_code_gry),
    .dcc_done     (dcc_done),
    .cal_busy     (cal_busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic restart();
    @(negedge clk) reinit = 1'b1;
    @(negedge clk) reinit = 1'b0;
  endtask
  task automatic sar_wait(output int n);
    n = 0;
    @(posedge clk);
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (dcc_done) break;
    end
  endtask
  initial begin
    nrst = 1'b0; rb_dcc_byp = 1'b1; rb_cont_cal = 1'b0; reinit = 1'b0;
    mode = 2'd0; up_v = 1'b0; dn_v = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code", dcc_code, 8'h80);
    check("rst_gry", dcc_code_gry, 8'hC0);
    check("rst_done", dcc_done, 1'b0);
    check("rst_busy", cal_busy, 1'b0);
    nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("byp_done", dcc_done, 1'b1);
      check("byp_code", dcc_code, 8'h80);
    end
    check("byp_busy", cal_busy, 1'b0);
    rb_dcc_byp = 1'b0;
    sar_wait(cyc);
    check("sar_cycles", cyc, 200);
    check("sar_code", dcc_code, 8'h5A);
    check("sar_gry", dcc_code_gry, 8'h77);
    check("sar_busy", cal_busy, 1'b0);
    repeat (40) @(negedge clk);
    check("sar_hold", dcc_code, 8'h5A);
    restart();
    @(posedge clk);
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("mid_code", dcc_code, 8'h50);
    check("mid_busy", cal_busy, 1'b1);
    reinit = 1'b1;
    @(negedge clk);
    check("reinit_code", dcc_code, 8'h80);
    check("reinit_gry", dcc_code_gry, 8'hC0);
    check("reinit_done", dcc_done, 1'b0);
    repeat (5) @(negedge clk);
    check("reinit_held", cal_busy, 1'b0);
    reinit = 1'b0;
    sar_wait(cyc);
    check("resar_cycles", cyc, 200);
    check("resar_code", dcc_code, 8'h5A);
    mode = 2'd1; up_v = 1'b1; dn_v = 1'b0;
    restart();
    sar_wait(cyc);
    check("up_cycles", cyc, 200);
    check("up_code", dcc_code, 8'hFF);
    check("up_gry", dcc_code_gry, 8'h80);
    rb_cont_cal = 1'b1;
    repeat (100) @(negedge clk);
    check("trk_sat_code", dcc_code, 8'hFF);
    check("trk_done", dcc_done, 1'b1);
    check("trk_busy", cal_busy, 1'b1);
    up_v = 1'b0; dn_v = 1'b1;
    cyc = 0;
    while (dcc_code == 8'hFF && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("trk_dec1", dcc_code, 8'hFE);
    repeat (24) @(negedge clk);
    check("trk_hold24", dcc_code, 8'hFE);
    @(negedge clk);
    check("trk_dec2", dcc_code, 8'hFD);
    check("trk_dec2_gry", dcc_code_gry, 8'h83);
    mode = 2'd2;
    repeat (100) @(negedge clk);
    check("marginal_code", dcc_code, 8'hFD);
    check("marginal_done", dcc_done, 1'b1);
    rb_cont_cal = 1'b0;
    repeat (30) @(negedge clk);
    check("untrk_busy", cal_busy, 1'b0);
    check("untrk_done", dcc_done, 1'b1);
    check("untrk_code", dcc_code, 8'hFD);
    mode = 2'd1; up_v = 1'b0; dn_v = 1'b1;
    restart();
    sar_wait(cyc);
    check("dn_cycles", cyc, 200);
    check("dn_code", dcc_code, 8'h00);
    check("dn_gry", dcc_code_gry, 8'h00);
    up_v = 1'b1; dn_v = 1'b1;
    restart();
    sar_wait(cyc);
    check("both_cycles", cyc, 200);
    check("both_code", dcc_code, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
